// File: rtl/dequantizer_if.sv
// Stream bundle for the dequantizer: int8 beats in, wide fixed-point beats out.
// The slave modport is the dequantizer itself; master is whoever drives it.
interface dequantizer_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int CH_W  = 2
) ();
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic [CH_W-1:0]  m_ch;
    logic             m_last;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_ch, m_last
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_ch, m_last
    );
endinterface

// File: rtl/dequantizer.sv
// Expands signed int8 activations to saturated fixed-point using a
// run-time per-channel multiplier/shift table; two-stage valid/ready pipe.
module dequantizer #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 32,
    parameter int NUM_CH     = 4,
    parameter int MULT_W     = 16,
    parameter int SHIFT_W    = 5,
    parameter int ZERO_POINT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [MULT_W-1:0]         cfg_mult,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    dequantizer_if.slave              io
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DIFF_W = IN_W + 2;
    localparam int PROD_W = IN_W + MULT_W + 3;
    localparam int SH_MAX = 1 << SHIFT_W;
    localparam int RW0    = (PROD_W > SH_MAX) ? PROD_W : SH_MAX;
    // Wide enough for the rounding bias at the largest shift and the clamp bounds
    localparam int RW     = ((RW0 > OUT_W) ? RW0 : OUT_W) + 2;
    localparam logic signed [RW-1:0] SAT_HI =
        (RW'(1) <<< (OUT_W - 1)) - RW'(1);
    localparam logic signed [RW-1:0] SAT_LO =
        -(RW'(1) <<< (OUT_W - 1));

    logic [MULT_W-1:0]  mult_q  [NUM_CH];
    logic [SHIFT_W-1:0] shift_q [NUM_CH];
    logic [CH_W-1:0]    ch_q, ch_d;

    logic                     v1_q;
    logic signed [PROD_W-1:0] prod1_q;
    logic [CH_W-1:0]          ch1_q;
    logic [SHIFT_W-1:0]       sh1_q;
    logic                     last1_q;

    logic             m_valid_q;
    logic [OUT_W-1:0] m_data_q;
    logic [CH_W-1:0]  m_ch_q;
    logic             m_last_q;

    logic                     en, acc;
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [RW-1:0]     bias, r;
    logic [OUT_W-1:0]         sat_d;

    always_comb begin
        en   = !m_valid_q || io.m_ready;
        acc  = io.s_valid && en;
        ch_d = ch_q;
        if (acc) begin
            if (io.s_last || ch_q == CH_W'(NUM_CH - 1)) ch_d = '0;
            else ch_d = ch_q + CH_W'(1);
        end
        diff   = DIFF_W'($signed(io.s_data)) - DIFF_W'(ZERO_POINT);
        prod_d = PROD_W'(diff) * PROD_W'($signed({1'b0, mult_q[ch_q]}));
        bias   = '0;
        if (sh1_q != '0) bias = RW'(1) <<< (sh1_q - SHIFT_W'(1));
        r     = (RW'(prod1_q) + bias) >>> sh1_q;
        sat_d = OUT_W'(r);
        if (r > SAT_HI) sat_d = SAT_HI[OUT_W-1:0];
        if (r < SAT_LO) sat_d = SAT_LO[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mult_q[i]  <= MULT_W'(1);
                shift_q[i] <= '0;
            end
            ch_q      <= '0;
            v1_q      <= 1'b0;
            prod1_q   <= '0;
            ch1_q     <= '0;
            sh1_q     <= '0;
            last1_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            m_last_q  <= 1'b0;
        end else begin
            ch_q <= ch_d;
            if (cfg_we && int'(cfg_ch) < NUM_CH) begin
                mult_q[cfg_ch]  <= cfg_mult;
                shift_q[cfg_ch] <= cfg_shift;
            end
            if (en) begin
                v1_q <= acc;
                if (acc) begin
                    prod1_q <= prod_d;
                    ch1_q   <= ch_q;
                    sh1_q   <= shift_q[ch_q];
                    last1_q <= io.s_last;
                end
                m_valid_q <= v1_q;
                if (v1_q) begin
                    m_data_q <= sat_d;
                    m_ch_q   <= ch1_q;
                    m_last_q <= last1_q;
                end
            end
        end
    end

    assign io.s_ready = en;
    assign io.m_valid = m_valid_q;
    assign io.m_data  = m_data_q;
    assign io.m_ch    = m_ch_q;
    assign io.m_last  = m_last_q;
endmodule

// File: tb/tb_dequantizer.sv
// Bench for dequantizer: directed scenarios plus random traffic, checked
// against a queue-based arithmetic model of the dequantization rules.
module tb_dequantizer;
    localparam int OUT_W  = 16;
    localparam int NUM_CH = 4;
    localparam int ZP     = 0;
    localparam longint HI = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint LO = -(longint'(1) << (OUT_W - 1));

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_mult;
    logic [4:0]  cfg_shift;

    dequantizer_if #(.IN_W(8), .OUT_W(OUT_W), .CH_W(2)) io ();

    dequantizer #(
        .IN_W(8), .OUT_W(OUT_W), .NUM_CH(NUM_CH),
        .MULT_W(16), .SHIFT_W(5), .ZERO_POINT(ZP)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .io(io)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint d;
        int     ch;
        bit     last;
        int     cyc;
    } exp_t;

    exp_t   exp_q[$];
    longint obs_d[$];
    int     obs_ch[$];
    bit     obs_last[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_low = 0;
    int mdl_mult[NUM_CH];
    int mdl_shift[NUM_CH];
    int mdl_ch = 0;
    bit after_rst = 0;
    bit acc_flag = 0;
    bit stall_prev = 0;
    longint held_d;
    int held_ch;
    bit held_last;

    task automatic check(input string nm, input logic signed [63:0] act,
                         input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint model_val(input int s, input int mult,
                                         input int sh);
        longint p;
        p = longint'(s - ZP) * longint'(mult);
        if (sh > 0) p = (p + (longint'(1) << (sh - 1))) >>> sh;
        if (p > HI) p = HI;
        if (p < LO) p = LO;
        return p;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        mdl_ch = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            mdl_mult[i]  = 1;
            mdl_shift[i] = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            after_rst  = 1;
            acc_flag   = 0;
            stall_prev = 0;
        end else begin
            if (after_rst) begin
                check("mvalid_after_rst", io.m_valid, 0);
                after_rst = 0;
            end
            check("s_ready", io.s_ready, !io.m_valid || io.m_ready);
            if (stall_prev) begin
                check("stall_valid", io.m_valid, 1);
                check("stall_data", $signed(io.m_data), held_d);
                check("stall_ch", io.m_ch, held_ch);
                check("stall_last", io.m_last, held_last);
            end
            if (io.m_valid && io.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", io.m_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("m_data", $signed(io.m_data), e.d);
                    check("m_ch", io.m_ch, e.ch);
                    check("m_last", io.m_last, e.last);
                    check("latency_min", (cyc - e.cyc) >= 2, 1);
                    if (last_low < e.cyc) check("latency", cyc - e.cyc, 2);
                    obs_d.push_back(longint'($signed(io.m_data)));
                    obs_ch.push_back(int'(io.m_ch));
                    obs_last.push_back(io.m_last);
                end
            end
            stall_prev = io.m_valid && !io.m_ready;
            held_d     = longint'($signed(io.m_data));
            held_ch    = int'(io.m_ch);
            held_last  = io.m_last;
            if (!io.m_ready) last_low = cyc;
            acc_flag = io.s_valid && io.s_ready;
            if (acc_flag) begin
                exp_t e;
                e.d    = model_val(int'($signed(io.s_data)),
                                   mdl_mult[mdl_ch], mdl_shift[mdl_ch]);
                e.ch   = mdl_ch;
                e.last = io.s_last;
                e.cyc  = cyc;
                exp_q.push_back(e);
                if (io.s_last || mdl_ch == NUM_CH - 1) mdl_ch = 0;
                else mdl_ch = mdl_ch + 1;
            end
            if (cfg_we && int'(cfg_ch) < NUM_CH) begin
                mdl_mult[cfg_ch]  = int'(cfg_mult);
                mdl_shift[cfg_ch] = int'(cfg_shift);
            end
        end
        cyc++;
    end

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic cfg(input int ch, input int mult, input int sh);
        cfg_we    = 1;
        cfg_ch    = 2'(ch);
        cfg_mult  = 16'(mult);
        cfg_shift = 5'(sh);
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    task automatic send(input int d, input bit last);
        int n = 0;
        io.s_valid = 1;
        io.s_data  = 8'(d);
        io.s_last  = last;
        @(negedge clk);
        while (!io.s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("send_accept", io.s_ready, 1);
        @(posedge clk); #1;
        io.s_valid = 0;
        io.s_last  = 0;
    endtask

    task automatic drain();
        int n = 0;
        io.m_ready = 1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic clear_obs();
        obs_d.delete();
        obs_ch.delete();
        obs_last.delete();
    endtask

    task automatic chk_obs(input string t, input int i, input longint d,
                           input int ch, input int last);
        check($sformatf("%s_d%0d", t, i), obs_d[i], d);
        check($sformatf("%s_ch%0d", t, i), obs_ch[i], ch);
        check($sformatf("%s_last%0d", t, i), obs_last[i], last);
    endtask

    initial begin
        rst        = 1;
        cfg_we     = 0;
        cfg_ch     = 0;
        cfg_mult   = 0;
        cfg_shift  = 0;
        io.s_valid = 0;
        io.s_data  = 0;
        io.s_last  = 0;
        io.m_ready = 1;
        model_reset();

        check("pin_round_pos", model_val(5, 3, 1), 8);
        check("pin_round_neg", model_val(-5, 3, 1), -7);
        check("pin_sat_hi", model_val(127, 65535, 0), 32767);
        check("pin_sat_lo", model_val(-128, 65535, 0), -32768);

        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_m_valid", io.m_valid, 0);
        check("rst_m_data", io.m_data, 0);
        check("rst_m_ch", io.m_ch, 0);
        check("rst_m_last", io.m_last, 0);
        check("rst_s_ready", io.s_ready, 1);
        rst = 0;

        // identity table after reset
        clear_obs();
        send(-128, 0);
        send(0, 0);
        send(127, 0);
        drain();
        check("t1_count", obs_d.size(), 3);
        chk_obs("t1", 0, -128, 0, 0);
        chk_obs("t1", 1, 0, 1, 0);
        chk_obs("t1", 2, 127, 2, 0);

        do_reset();
        clear_obs();
        cfg(0, 3, 1);
        send(5, 1);
        send(-5, 1);
        drain();
        check("t2_count", obs_d.size(), 2);
        chk_obs("t2", 0, 8, 0, 1);
        chk_obs("t2", 1, -7, 0, 1);

        do_reset();
        clear_obs();
        for (int i = 0; i < 6; i++) send(i + 1, 0);
        drain();
        check("t3a_count", obs_d.size(), 6);
        for (int i = 0; i < 6; i++) chk_obs("t3a", i, i + 1, i % 4, 0);

        do_reset();
        clear_obs();
        send(1, 0);
        send(2, 1);
        send(3, 0);
        send(4, 0);
        drain();
        check("t3b_count", obs_d.size(), 4);
        chk_obs("t3b", 0, 1, 0, 0);
        chk_obs("t3b", 1, 2, 1, 1);
        chk_obs("t3b", 2, 3, 0, 0);
        chk_obs("t3b", 3, 4, 1, 0);

        do_reset();
        clear_obs();
        fork
            begin
                for (int i = 0; i < 10; i++) send(i * 11 - 50, 0);
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                io.m_ready = 0;
                repeat (5) begin @(posedge clk); #1; end
                io.m_ready = 1;
            end
        join
        drain();
        check("t4_count", obs_d.size(), 10);
        for (int i = 0; i < 10; i++) chk_obs("t4", i, i * 11 - 50, i % 4, 0);

        do_reset();
        clear_obs();
        cfg(0, 65535, 0);
        cfg(1, 65535, 0);
        send(127, 0);
        send(-128, 0);
        drain();
        check("t5_count", obs_d.size(), 2);
        chk_obs("t5", 0, 32767, 0, 0);
        chk_obs("t5", 1, -32768, 1, 0);

        do_reset();
        cfg(0, 7, 2);
        cfg(1, 7, 2);
        io.m_ready = 0;
        send(20, 0);
        send(30, 0);
        check("t6_inflight", io.m_valid, 1);
        do_reset();
        check("t6_mvalid_rst", io.m_valid, 0);
        io.m_ready = 1;
        clear_obs();
        send(9, 0);
        drain();
        check("t6_count", obs_d.size(), 1);
        chk_obs("t6", 0, 9, 0, 0);

        for (int k = 0; k < 4000; k++) begin
            bit was_rst;
            was_rst = rst;
            rst = ($urandom_range(0, 299) == 0);
            if (!io.s_valid || acc_flag || was_rst) begin
                io.s_valid = ($urandom_range(0, 9) < 7);
                io.s_data  = 8'($urandom);
                io.s_last  = ($urandom_range(0, 4) == 0);
            end
            io.m_ready = ($urandom_range(0, 9) < 7);
            cfg_we     = ($urandom_range(0, 11) == 0);
            cfg_ch     = 2'($urandom);
            cfg_mult   = ($urandom_range(0, 3) == 0) ?
                         16'($urandom_range(0, 4)) : 16'($urandom);
            cfg_shift  = ($urandom_range(0, 2) == 0) ?
                         5'($urandom) : 5'($urandom_range(0, 12));
            @(posedge clk); #1;
        end
        rst        = 0;
        cfg_we     = 0;
        io.s_valid = 0;
        io.s_last  = 0;
        @(posedge clk); #1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
